result_buffer: RTL and testbench

//   Downstream stage of the dedicated microprocessor datapath. Captures each 8-bit
//   ALU result strobed by the control unit's load signal into a small FIFO. Presents

---
 rtl/result_buffer.sv | 182 ++++++++++++++++++
 tb/tb_result_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_buffer.sv
// result_buffer: captures strobed ALU results into a small FIFO with a valid/ready
// output; an end-of-run strobe drains it. Optional feature macro: RESULT_ZERO_FLAG_EN.
module result_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_load,
    input  logic                   in_done,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [CNT_W-1:0]       run_cnt,
`ifdef RESULT_ZERO_FLAG_EN
    output logic                   out_zero,
`endif
    output logic                   drained
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
`ifdef RESULT_ZERO_FLAG_EN
    localparam int unsigned ENT_W = DATA_W + 1;
`else
    localparam int unsigned ENT_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               valid_q, valid_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic               drained_q, drained_d;
    logic [ENT_W-1:0]   head_q, head_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];

    logic               push_c;
    logic               pop_c;
    logic [ENT_W-1:0]   entry_c;

`ifdef RESULT_ZERO_FLAG_EN
    logic               zero_q, zero_d;
    assign entry_c = {in_data == '0, in_data};
`else
    assign entry_c = in_data;
`endif

    assign pop_c  = valid_q & out_ready;
    assign push_c = in_load & (state_q != DRAIN) & (~full_q | pop_c);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        run_cnt_d  = run_cnt_q;
        drained_d  = 1'b0;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (run_cnt_q != '1) begin
                run_cnt_d = run_cnt_q + CNT_W'(1);
            end
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (in_load && (state_q != DRAIN) && full_q && !pop_c) begin
            overflow_d = 1'b1;
        end

        level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
        valid_d = (level_d != '0);
        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_W'(DEPTH));

        // New head is the entry written this edge only when it lands at the read pointer
        if (push_c && (rd_ptr_d == wr_ptr_q)) begin
            head_d = entry_c;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end

        case (state_q)
            IDLE: begin
                if (in_done) begin
                    state_d = DRAIN;
                end else if (in_load) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (in_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (level_d == '0) begin
                    state_d   = IDLE;
                    drained_d = 1'b1;
                    run_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef RESULT_ZERO_FLAG_EN
        zero_d = head_d[DATA_W] & valid_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            run_cnt_q  <= '0;
            drained_q  <= 1'b0;
            head_q     <= '0;
`ifdef RESULT_ZERO_FLAG_EN
            zero_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            run_cnt_q  <= run_cnt_d;
            drained_q  <= drained_d;
            head_q     <= head_d;
`ifdef RESULT_ZERO_FLAG_EN
            zero_q     <= zero_d;
`endif
        end
    end

    // Entry storage is deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= entry_c;
        end
    end

    assign out_data  = head_q[DATA_W-1:0];
    assign out_valid = valid_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign run_cnt   = run_cnt_q;
    assign drained   = drained_q;
`ifdef RESULT_ZERO_FLAG_EN
    assign out_zero  = zero_q;
`endif

endmodule

// File: tb/tb_result_buffer.sv
// Directed bench for result_buffer: ordering, full/overflow, drain, reset, zero flag.
module tb_result_buffer;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_load;
    logic       in_done;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] run_cnt;
    logic       drained;
`ifdef RESULT_ZERO_FLAG_EN
    logic       out_zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    result_buffer #(.DATA_W(8), .DEPTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_load   (in_load),
        .in_done   (in_done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .run_cnt   (run_cnt),
`ifdef RESULT_ZERO_FLAG_EN
        .out_zero  (out_zero),
`endif
        .drained   (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        in_data   = 8'h00;
        in_load   = 1'b0;
        in_done   = 1'b0;
        out_ready = 1'b0;

        // reset state
        cyc();
        cyc();
        check("rst_empty",    32'(empty),     1);
        check("rst_valid",    32'(out_valid), 0);
        check("rst_level",    32'(level),     0);
        check("rst_overflow", 32'(overflow),  0);
        check("rst_run_cnt",  32'(run_cnt),   0);
        check("rst_full",     32'(full),      0);
        check("rst_drained",  32'(drained),   0);
        reset = 1'b1;
        cyc();

        // ordering with one-cycle latency
        in_load = 1'b1; in_data = 8'h12;
        cyc();
        check("lat_valid", 32'(out_valid), 1);
        check("lat_data",  32'(out_data),  32'h12);
        in_data = 8'h34;
        cyc();
        in_data = 8'h56;
        cyc();
        in_load = 1'b0;
        check("ord_level",   32'(level),    3);
        check("ord_run_cnt", 32'(run_cnt),  3);
        check("ord_hold",    32'(out_data), 32'h12);
        cyc();
        check("ord_stable",  32'(out_data), 32'h12);
        out_ready = 1'b1;
        cyc();
        check("ord_pop2", 32'(out_data), 32'h34);
        check("ord_lvl2", 32'(level),    2);
        cyc();
        check("ord_pop3", 32'(out_data), 32'h56);
        cyc();
        check("ord_empty", 32'(empty),     1);
        check("ord_valid", 32'(out_valid), 0);
        out_ready = 1'b0;

        // close the run from an empty FIFO
        in_done = 1'b1;
        cyc();
        in_done = 1'b0;
        check("close_no_pulse", 32'(drained), 0);
        cyc();
        check("close_drained", 32'(drained), 1);
        check("close_run_cnt", 32'(run_cnt), 0);
        cyc();
        check("close_pulse_end", 32'(drained), 0);

        // fill, overflow, push-while-full with pop
        for (int i = 1; i <= 4; i++) begin
            in_load = 1'b1; in_data = 8'(i);
            cyc();
        end
        check("full_flag",  32'(full),     1);
        check("full_level", 32'(level),    4);
        check("full_ovf0",  32'(overflow), 0);
        in_data = 8'h05;
        cyc();
        check("ovf_set",     32'(overflow), 1);
        check("ovf_level",   32'(level),    4);
        check("ovf_run_cnt", 32'(run_cnt),  4);
        in_data = 8'h06; out_ready = 1'b1;
        cyc();
        in_load = 1'b0;
        check("pp_level",   32'(level),    4);
        check("pp_run_cnt", 32'(run_cnt),  5);
        check("pp_head",    32'(out_data), 2);
        check("pp_ovf",     32'(overflow), 1);
        cyc();
        check("pp_q3", 32'(out_data), 3);
        cyc();
        check("pp_q4", 32'(out_data), 4);
        cyc();
        check("pp_q6", 32'(out_data), 6);
        cyc();
        check("pp_empty", 32'(empty), 1);
        out_ready = 1'b0;

        // reset mid-run with data held
        in_load = 1'b1;
        in_data = 8'hB1; cyc();
        in_data = 8'hB2; cyc();
        in_data = 8'hB3; cyc();
        in_load = 1'b0;
        check("pre_rst_level", 32'(level),     3);
        check("pre_rst_valid", 32'(out_valid), 1);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check("mid_rst_empty", 32'(empty),     1);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_ovf",   32'(overflow),  0);
        check("mid_rst_level", 32'(level),     0);
        check("mid_rst_cnt",   32'(run_cnt),   0);
        in_load = 1'b1; in_data = 8'hA5;
        cyc();
        in_load = 1'b0;
        check("post_rst_valid", 32'(out_valid), 1);
        check("post_rst_data",  32'(out_data),  32'hA5);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("post_rst_empty", 32'(empty), 1);

        // drain with loads ignored
        in_load = 1'b1;
        in_data = 8'hA1; cyc();
        in_data = 8'hA2; cyc();
        in_load = 1'b0;
        check("dr_level",   32'(level),   2);
        check("dr_run_cnt", 32'(run_cnt), 3);
        in_done = 1'b1;
        cyc();
        in_done = 1'b0;
        in_load = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        cyc();
        check("dr_pop1_level", 32'(level),    1);
        check("dr_pop1_data",  32'(out_data), 32'hA2);
        check("dr_pop1_pulse", 32'(drained),  0);
        check("dr_no_ovf",     32'(overflow), 0);
        cyc();
        in_load = 1'b0;
        check("dr_drained", 32'(drained),   1);
        check("dr_empty",   32'(empty),     1);
        check("dr_valid",   32'(out_valid), 0);
        check("dr_run_cnt0", 32'(run_cnt),  0);
        check("dr_no_ovf2", 32'(overflow),  0);
        cyc();
        check("dr_pulse_end", 32'(drained), 0);
        check("dr_still_empty", 32'(empty), 1);
        out_ready = 1'b0;

        // back in IDLE a load starts a new run
        in_load = 1'b1; in_data = 8'h3C;
        cyc();
        in_load = 1'b0;
        check("idle_load_data", 32'(out_data), 32'h3C);
        check("idle_load_cnt",  32'(run_cnt),  1);

`ifdef RESULT_ZERO_FLAG_EN
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check("zf_reset", 32'(out_zero), 0);
        in_load = 1'b1; in_data = 8'h00;
        cyc();
        check("zf_zero", 32'(out_zero), 1);
        in_data = 8'h01;
        cyc();
        in_load = 1'b0;
        check("zf_hold", 32'(out_zero), 1);
        out_ready = 1'b1;
        cyc();
        check("zf_nonzero", 32'(out_zero), 0);
        cyc();
        out_ready = 1'b0;
        check("zf_invalid", 32'(out_zero), 0);
        check("zf_empty",   32'(empty),    1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
